// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus state encoding, mode constants and default widths
// Purpose: common types for the master, arbiter and slave ports of the serial bus.
// Contents: state_t FSM encoding, MODE_* constants, DEF_* widths, max3 helper.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEV,
    ST_WAIT_ACK,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_RESP
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEF_DEV_WIDTH  = 5;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - PISO/SIPO shift register with bit counter
// Purpose: MSB-first serial shifter used for both transmit and receive paths.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            load i_load_data and clear the bit counter
//   i_load_data       parallel value to load
//   i_shift           shift left one bit, i_sin enters at the LSB
//   i_sin             serial input bit
//   i_len             number of bits in the current field
//   o_sout            current serial output bit (MSB)
//   o_data            parallel register contents
//   o_done            the current bit is the last one of the field
module serial_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_sin,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_sout,
  output logic [WIDTH-1:0] o_data,
  output logic             o_done
);

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_sin};
      // Saturate at the field length so the counter never wraps.
      if (r_cnt != i_len) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sout = r_data[WIDTH-1];
  assign o_data = r_data;
  assign o_done = (r_cnt == i_len - CNT_W'(1));

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - master-side bit-serial bus port
// Purpose: turns one parallel core request into the serial dev/ack/addr/data
// handshake toward the arbiter and returns one parallel response.
// Ports:
//   i_clk, i_rst                           clock, synchronous active-high reset
//   i_req_valid/o_req_ready                core request handshake
//   i_req_mode/dev/addr/wdata              request fields (mode 0=read, 1=write)
//   o_rsp_valid/i_rsp_ready                core response handshake
//   o_rsp_err, o_rsp_rdata                 response status and read data
//   o_mode                                 transaction mode to the bus
//   o_wr_bus/o_master_valid/i_slave_ready  master-to-bus serial handshake
//   i_rd_bus/i_slave_valid/o_master_ready  bus-to-master serial handshake
//   i_ack                                  arbiter ack, qualified by i_slave_valid
module bus_master_port import bus_pkg::*; #(
  parameter int DEV_WIDTH   = DEF_DEV_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_mode,
  input  logic [DEV_WIDTH-1:0]  i_req_dev,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_err,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_mode,
  output logic                  o_wr_bus,
  output logic                  o_master_valid,
  input  logic                  i_slave_ready,
  input  logic                  i_rd_bus,
  input  logic                  i_slave_valid,
  output logic                  o_master_ready,
  input  logic                  i_ack
);

  localparam int TXW   = max3(DEV_WIDTH, ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W = $clog2(TXW + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  state_t                r_state, w_next;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [TO_W-1:0]       r_to_cnt;

  logic                  w_tx_load, w_tx_xfer, w_tx_done, w_tx_sout;
  logic [TXW-1:0]        w_tx_load_data, w_tx_data_unused;
  logic [CNT_W-1:0]      w_tx_len;
  logic                  w_accept, w_rx_shift, w_rx_done, w_rx_sout_unused;
  logic [DATA_WIDTH-1:0] w_rx_data;

  assign w_accept   = (r_state == ST_IDLE) && i_req_valid;
  assign w_tx_xfer  = o_master_valid && i_slave_ready;
  assign w_rx_shift = (r_state == ST_RDATA) && i_slave_valid;

  // Fields are left-aligned in the shared transmit register so the MSB is sent first.
  always_comb begin
    w_tx_load      = 1'b0;
    w_tx_load_data = '0;
    case (r_state)
      ST_IDLE: if (i_req_valid) begin
        w_tx_load      = 1'b1;
        w_tx_load_data = TXW'(i_req_dev) << (TXW - DEV_WIDTH);
      end
      ST_WAIT_ACK: if (i_slave_valid && i_ack) begin
        w_tx_load      = 1'b1;
        w_tx_load_data = TXW'(r_addr) << (TXW - ADDR_WIDTH);
      end
      ST_ADDR: if (w_tx_xfer && w_tx_done && r_mode == MODE_WRITE) begin
        w_tx_load      = 1'b1;
        w_tx_load_data = TXW'(r_wdata) << (TXW - DATA_WIDTH);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_state)
      ST_ADDR:  w_tx_len = CNT_W'(ADDR_WIDTH);
      ST_WDATA: w_tx_len = CNT_W'(DATA_WIDTH);
      default:  w_tx_len = CNT_W'(DEV_WIDTH);
    endcase
  end

  serial_shifter #(.WIDTH(TXW), .CNT_W(CNT_W)) u_tx (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(w_tx_load), .i_load_data(w_tx_load_data),
    .i_shift(w_tx_xfer), .i_sin(1'b0), .i_len(w_tx_len),
    .o_sout(w_tx_sout), .o_data(w_tx_data_unused), .o_done(w_tx_done)
  );

  // Cleared on accept so write and error responses carry zero read data.
  serial_shifter #(.WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_rx (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(w_accept), .i_load_data('0),
    .i_shift(w_rx_shift), .i_sin(i_rd_bus), .i_len(CNT_W'(DATA_WIDTH)),
    .o_sout(w_rx_sout_unused), .o_data(w_rx_data), .o_done(w_rx_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_req_valid) w_next = ST_DEV;
      ST_DEV:      if (w_tx_xfer && w_tx_done) w_next = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        // A response in the expiry cycle wins over the timeout.
        if (i_slave_valid)                               w_next = i_ack ? ST_ADDR : ST_RESP;
        else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1))     w_next = ST_RESP;
      end
      ST_ADDR:     if (w_tx_xfer && w_tx_done)
                     w_next = (r_mode == MODE_WRITE) ? ST_WDATA : ST_RDATA;
      ST_WDATA:    if (w_tx_xfer && w_tx_done) w_next = ST_RESP;
      ST_RDATA:    if (w_rx_shift && w_rx_done) w_next = ST_RESP;
      ST_RESP:     if (i_rsp_ready) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready    = 1'b0;
    o_master_valid = 1'b0;
    o_master_ready = 1'b0;
    o_wr_bus       = 1'b0;
    o_mode         = 1'b0;
    o_rsp_valid    = 1'b0;
    o_rsp_err      = 1'b0;
    o_rsp_rdata    = '0;
    case (r_state)
      ST_IDLE:     o_req_ready = 1'b1;
      ST_DEV, ST_ADDR, ST_WDATA: begin
        o_master_valid = 1'b1;
        o_wr_bus       = w_tx_sout;
        o_mode         = r_mode;
      end
      ST_WAIT_ACK, ST_RDATA: begin
        o_master_ready = 1'b1;
        o_mode         = r_mode;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = r_err;
        o_rsp_rdata = w_rx_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode   <= MODE_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_mode  <= i_req_mode;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_err   <= 1'b0;
      end
      if (r_state == ST_WAIT_ACK) begin
        if (!i_slave_valid) r_to_cnt <= r_to_cnt + TO_W'(1);
        if (w_next == ST_RESP) r_err <= 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - randomized self-checking bench for bus_master_port
module tb_bus_master_port;

  localparam int DW = 5;
  localparam int AW = 12;
  localparam int XW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          i_rst, i_req_valid, i_req_mode, i_rsp_ready;
  logic [DW-1:0] i_req_dev;
  logic [AW-1:0] i_req_addr;
  logic [XW-1:0] i_req_wdata;
  logic          i_slave_ready, i_rd_bus, i_slave_valid, i_ack;
  logic          o_req_ready, o_rsp_valid, o_rsp_err, o_mode, o_wr_bus;
  logic          o_master_valid, o_master_ready;
  logic [XW-1:0] o_rsp_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_master_port #(.DEV_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_WIDTH(XW), .ACK_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_mode(i_req_mode),
    .i_req_dev(i_req_dev), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_err(o_rsp_err),
    .o_rsp_rdata(o_rsp_rdata), .o_mode(o_mode), .o_wr_bus(o_wr_bus),
    .o_master_valid(o_master_valid), .i_slave_ready(i_slave_ready),
    .i_rd_bus(i_rd_bus), .i_slave_valid(i_slave_valid),
    .o_master_ready(o_master_ready), .i_ack(i_ack)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bp: 0 = bus always ready, 1 = alternating 1,0, 2 = random.
  // rst_at: pulse reset when this many bits have been transferred (-1 = never).
  task automatic run_txn(input logic m, input logic [DW-1:0] dev, input logic [AW-1:0] addr,
                         input logic [XW-1:0] wd, input logic [XW-1:0] rd, input int ack_dly,
                         input logic ack_v, input int bp, input int rsp_hold, input int rst_at);
    logic [31:0]   got_s, exp_s;
    logic [XW-1:0] exp_rd;
    logic          exp_err, acked, prev_hold, prev_bit, done, alt, go;
    int            got_n, exp_n, exp_lat, exp_wait, cyc, wait_n, rd_i;

    exp_err = (ack_dly >= TO) || !ack_v;
    exp_rd  = (!exp_err && !m) ? rd : '0;
    if (exp_err) begin
      exp_s    = 32'(dev);
      exp_n    = DW;
      exp_lat  = (ack_dly >= TO) ? 1 + DW + TO : 1 + DW + ack_dly + 1;
    end else begin
      exp_s    = m ? 32'({dev, addr, wd}) : 32'({dev, addr});
      exp_n    = m ? DW + AW + XW : DW + AW;
      exp_lat  = 1 + DW + ack_dly + 1 + AW + XW;
    end
    exp_wait = (ack_dly >= TO) ? TO : ack_dly + 1;

    chk_eq("req_ready_idle", 32'(o_req_ready), 1);
    i_req_valid = 1'b1; i_req_mode = m; i_req_dev = dev; i_req_addr = addr; i_req_wdata = wd;
    @(negedge clk);
    // Junk request while busy must be ignored.
    i_req_valid = 1'($urandom_range(0, 1));
    i_req_mode  = 1'($urandom_range(0, 1));
    i_req_dev   = DW'($urandom);
    i_req_addr  = AW'($urandom);
    i_req_wdata = XW'($urandom);
    chk_eq("req_ready_busy", 32'(o_req_ready), 0);

    got_s = '0; got_n = 0; wait_n = 0; rd_i = 0; cyc = 1;
    acked = 1'b0; prev_hold = 1'b0; prev_bit = 1'b0; done = 1'b0; alt = 1'b1;
    while (!done) begin
      i_slave_ready = 1'b0; i_slave_valid = 1'b0; i_ack = 1'b0; i_rd_bus = 1'b0; i_rsp_ready = 1'b0;
      alt = ~alt;
      go  = (bp == 0) ? 1'b1 : (bp == 1) ? ~alt : 1'($urandom_range(0, 1));
      if (cyc > 400) begin
        chk_eq("txn_budget", 32'(cyc), 32'(exp_lat));
        i_req_valid = 1'b0;
        done = 1'b1;
      end else if (o_rsp_valid) begin
        i_req_valid = 1'b0;
        if (bp == 0) chk_eq("latency", 32'(cyc), 32'(exp_lat));
        chk_eq("ack_wait", 32'(wait_n), 32'(exp_wait));
        chk_eq("rsp_err", 32'(o_rsp_err), 32'(exp_err));
        chk_eq("rsp_rdata", 32'(o_rsp_rdata), 32'(exp_rd));
        chk_eq("stream_len", 32'(got_n), 32'(exp_n));
        chk_eq("stream", got_s, exp_s);
        chk_eq("rsp_mode", 32'(o_mode), 0);
        chk_eq("rsp_mv", 32'(o_master_valid), 0);
        for (int h = 0; h < rsp_hold; h++) begin
          @(negedge clk);
          chk_eq("rsp_held", 32'(o_rsp_valid), 1);
          chk_eq("rsp_rdata_held", 32'(o_rsp_rdata), 32'(exp_rd));
        end
        i_rsp_ready = 1'b1;
        @(negedge clk);
        i_rsp_ready = 1'b0;
        chk_eq("rsp_drop", 32'(o_rsp_valid), 0);
        chk_eq("back_idle", 32'(o_req_ready), 1);
        done = 1'b1;
      end else if (o_master_valid) begin
        chk_eq("mode_tx", 32'(o_mode), 32'(m));
        chk_eq("mv_mr_excl", 32'(o_master_ready), 0);
        if (prev_hold) chk_eq("wr_bus_stable", 32'(o_wr_bus), 32'(prev_bit));
        if (rst_at >= 0 && got_n == rst_at) begin
          i_rst = 1'b1; i_req_valid = 1'b0;
          @(negedge clk);
          i_rst = 1'b0;
          chk_eq("rst_mv", 32'(o_master_valid), 0);
          chk_eq("rst_mr", 32'(o_master_ready), 0);
          chk_eq("rst_req_ready", 32'(o_req_ready), 1);
          chk_eq("rst_rsp_valid", 32'(o_rsp_valid), 0);
          chk_eq("rst_mode", 32'(o_mode), 0);
          done = 1'b1;
        end else begin
          i_slave_ready = go;
          prev_hold = ~go;
          prev_bit  = o_wr_bus;
          if (go) begin
            got_s = {got_s[30:0], o_wr_bus};
            got_n++;
          end
        end
      end else begin
        prev_hold = 1'b0;
        if (o_master_ready && !acked) begin
          if (wait_n == ack_dly) begin
            i_slave_valid = 1'b1; i_ack = ack_v; acked = 1'b1;
          end
          wait_n++;
        end else if (o_master_ready) begin
          chk_eq("mode_rx", 32'(o_mode), 32'(m));
          i_slave_valid = go;
          if (go) begin
            i_rd_bus = (rd_i < XW) ? rd[XW-1-rd_i] : 1'b0;
            rd_i++;
          end
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_mode = 1'b0; i_req_dev = '0; i_req_addr = '0;
    i_req_wdata = '0; i_rsp_ready = 1'b0; i_slave_ready = 1'b0; i_rd_bus = 1'b0;
    i_slave_valid = 1'b0; i_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("reset_mv", 32'(o_master_valid), 0);
    chk_eq("reset_mr", 32'(o_master_ready), 0);
    chk_eq("reset_mode", 32'(o_mode), 0);
    chk_eq("reset_wr_bus", 32'(o_wr_bus), 0);
    chk_eq("reset_rsp_valid", 32'(o_rsp_valid), 0);
    chk_eq("reset_rsp_err", 32'(o_rsp_err), 0);
    chk_eq("reset_rsp_rdata", 32'(o_rsp_rdata), 0);
    chk_eq("reset_req_ready", 32'(o_req_ready), 1);
    i_rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 5'b00010, 12'hA5C, 8'h3C, 8'h00, 0, 1'b1, 0, 0, -1);
    run_txn(1'b0, 5'b11000, 12'h001, 8'h00, 8'hA5, 0, 1'b1, 0, 0, -1);
    run_txn(1'b1, 5'h1F, 12'hFFF, 8'hFF, 8'h00, 3, 1'b0, 0, 1, -1);
    run_txn(1'b0, 5'h07, 12'h123, 8'h00, 8'h5A, TO, 1'b1, 0, 0, -1);
    run_txn(1'b0, 5'h07, 12'h123, 8'h00, 8'h5A, TO - 1, 1'b1, 0, 0, -1);
    run_txn(1'b1, 5'h15, 12'h6B3, 8'hC9, 8'h00, 2, 1'b1, 1, 3, -1);
    run_txn(1'b0, 5'h0A, 12'h9E1, 8'h00, 8'h3D, 1, 1'b1, 1, 3, -1);
    run_txn(1'b1, 5'h0C, 12'h3F0, 8'h81, 8'h00, 0, 1'b1, 0, 0, DW + 4);
    run_txn(1'b1, 5'b00010, 12'hA5C, 8'h3C, 8'h00, 0, 1'b1, 0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), DW'($urandom), AW'($urandom), XW'($urandom),
              XW'($urandom), int'($urandom_range(0, TO + 2)), ($urandom_range(0, 7) != 0),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DW + AW + XW - 1)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side serial bus interface. Converts one parallel request from the local master core (read or write, device select, memory address, write data) into the bit-serial handshake protocol driven into the arbiter's master-1 port.
- Serialises the device-select bits, waits for the arbiter ack, then serialises the memory address and write data, or deserialises read data.
- Returns one parallel response per request to the core.

Parameters:
- DEV_WIDTH, 5, device-select bits sent to the arbiter before ack.
- ADDR_WIDTH, 12, slave memory address bits.
- DATA_WIDTH, 8, data bits per transfer.
- ACK_TIMEOUT, 15, maximum cycles spent in WAIT_ACK before an error response.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  port can accept a request
- req_mode  in  1  0=read, 1=write
- req_dev  in  DEV_WIDTH  device select
- req_addr  in  ADDR_WIDTH  slave memory address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  core accepts response
- rsp_err  out  1  NACK or ack timeout
- rsp_rdata  out  DATA_WIDTH  read data (0 on write or error)
- mode  out  1  transaction mode to bus
- wr_bus  out  1  serial bit, master to bus
- master_valid  out  1  wr_bus bit valid
- slave_ready  in  1  bus accepts a bit
- rd_bus  in  1  serial bit, bus to master
- slave_valid  in  1  rd_bus/ack valid
- master_ready  out  1  master accepts rd_bus/ack
- ack  in  1  arbiter ack, sampled with slave_valid in WAIT_ACK

Behaviour:
- One clock and one reset: clk; rst is synchronous and active-high.
- Reset behaviour: rst forces state IDLE, clears all registers, and aborts any transfer without a response.
  - Outputs the cycle after reset: master_valid=0, master_ready=0, mode=0, wr_bus=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch mode/dev/addr/wdata, clear bit counter, go to DEV.
  - DEV: master_valid=1, wr_bus = dev bit, MSB first. A bit transfers when master_valid & slave_ready; the counter advances only on a transfer, and wr_bus stays stable otherwise. After DEV_WIDTH transfers, go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK: master_valid=0, master_ready=1.
    - slave_valid=1 with ack=1: go to ADDR.
    - slave_valid=1 with ack=0: set rsp_err, go to RESP.
    - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT with no slave_valid, set rsp_err and go to RESP.
    - slave_valid in the expiry cycle takes priority over the timeout.
  - ADDR: same bit handshake as DEV, ADDR_WIDTH bits MSB first. Then go to WDATA if mode=1, else RDATA.
  - WDATA: same handshake, DATA_WIDTH bits of wdata MSB first, then RESP.
  - RDATA: master_ready=1, master_valid=0. On slave_valid & master_ready, shift rd_bus into rdata LSB (MSB arrives first). After DATA_WIDTH bits, go to RESP.
  - RESP: rsp_valid=1, master_valid=0, master_ready=0. On rsp_ready, go to IDLE.
- Output rules:
  - mode is driven with the latched mode from DEV through RDATA/WDATA, and is 0 in IDLE, WAIT_ACK-abort paths and RESP.
  - req_ready is 0 outside IDLE; a request presented during a transaction is not accepted.
- Minimum write latency (slave_ready tied high, ack in the first WAIT_ACK cycle): 1 + DEV_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH cycles from request accept to rsp_valid, i.e. 27 cycles at default parameters.
- Counters: bit counter width is clog2(max(DEV_WIDTH,ADDR_WIDTH,DATA_WIDTH)+1). It cleared on every phase entry and never wraps within a phase.

Decomposition:
- Shared bus_pkg:
  - state enum (IDLE, DEV, WAIT_ACK, ADDR, WDATA, RDATA, RESP)
  - mode encoding constants MODE_READ=0, MODE_WRITE=1
  - default DEV/ADDR/DATA widths, also reused by the arbiter and slave ports
- One natural sub-module: serial_shifter, a parameterised PISO/SIPO shift register with load, shift-enable and done flag, instantiated for the transmit and receive paths.

Test Plan:
- Write, slave_ready=1, dev=5'b00010, addr=12'hA5C, wdata=8'h3C, ack=1:
  - wr_bus shows 0,0,0,1,0, then A5C MSB-first, then 0,0,1,1,1,1,0,0.
  - rsp_valid at cycle 27 with rsp_err=0.
- Read, dev=5'b11000, addr=12'h001, ack=1, bus returns rd_bus 1,0,1,0,0,1,0,1:
  - rsp_rdata=8'hA5, rsp_err=0, mode=0 throughout.
- NACK: ack=0 with slave_valid in WAIT_ACK -> no further master_valid, rsp_err=1, rsp_rdata=0.
- Timeout: slave_valid held 0 -> after 15 WAIT_ACK cycles, rsp_err=1. slave_valid=1, ack=1 on cycle 15 -> proceeds to ADDR.
- Backpressure: slave_ready alternates 1,0 and rsp_ready is held low 3 cycles:
  - each wr_bus bit is stable while unaccepted and transferred exactly once.
  - rsp_valid and its data are held until rsp_ready.
- Reset mid-ADDR: rst=1 for one cycle -> next cycle master_valid=0, req_ready=1, no rsp_valid; a new request then completes normally.
